// File: rtl/pg_mon_pkg.sv
// Shared definitions for the power-good timeout monitor.
//   - FSM state encoding (3-bit localparams wrapped in an enum type)
//   - fault code constants reported on fault_code
package pg_mon_pkg;

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_WAIT_ON  = 3'd1;
  localparam logic [2:0] ST_ON       = 3'd2;
  localparam logic [2:0] ST_WAIT_OFF = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  typedef enum logic [2:0] {
    S_OFF      = ST_OFF,
    S_WAIT_ON  = ST_WAIT_ON,
    S_ON       = ST_ON,
    S_WAIT_OFF = ST_WAIT_OFF,
    S_FAULT    = ST_FAULT
  } state_t;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ON_TO   = 2'b01;
  localparam logic [1:0] FLT_PG_DROP = 2'b10;
  localparam logic [1:0] FLT_OFF_TO  = 2'b11;

endpackage

// File: rtl/pg_deglitch.sv
// Synchronizer plus deglitch filter for an asynchronous level input.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   tick     time-base strobe; the deglitch counter advances only on tick
//   dgl_cnt  ticks a new level must persist before it is accepted
//   sig_in   raw asynchronous input
//   sig_out  synchronized, filtered level (registered)
module pg_deglitch #(
  parameter int DGL_NBITS = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic [DGL_NBITS-1:0] dgl_cnt,
  input  logic                 sig_in,
  output logic                 sig_out
);

  logic [1:0]           sync;
  logic                 sig_s;
  logic [DGL_NBITS-1:0] gcnt;

  assign sig_s = sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would collapse the 2-flop
  // synchronizer into a single stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= 2'b00;
      sig_out <= 1'b0;
      gcnt    <= '0;
    end else begin
      sync <= {sync[0], sig_in};
      if (sig_s == sig_out) begin
        gcnt <= '0;
      end else if (gcnt == dgl_cnt) begin
        // Level has held for dgl_cnt ticks: accept it. With dgl_cnt=0 this
        // fires on the first clk of a difference.
        sig_out <= sig_s;
        gcnt    <= '0;
      end else if (tick) begin
        gcnt <= gcnt + DGL_NBITS'(1);
      end
    end
  end

endmodule

// File: rtl/pg_timeout_monitor.sv
// Power-good response checker for one sequenced rail.
// Watches the VR power-good return against the sequencer's enable and
// reports a qualified good plus a latched, coded fault.
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   tick         time-base strobe for all timeouts
//   en_in        rail enable from the sequencer (clk domain)
//   pg_in        raw VR power-good (asynchronous)
//   on_timeout   ticks allowed from enable to good
//   off_timeout  ticks allowed from disable to good low
//   dgl_cnt      deglitch hold time in ticks
//   fault_clr    clears a latched fault, only while en_in=0
//   pg_ok        rail qualified good (registered)
//   fault        latched fault (registered)
//   fault_code   00 none, 01 on-timeout, 10 pg dropped, 11 off-timeout
module pg_timeout_monitor
  import pg_mon_pkg::*;
#(
  parameter int CNTR_NBITS = 8,
  parameter int DGL_NBITS  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  en_in,
  input  logic                  pg_in,
  input  logic [CNTR_NBITS-1:0] on_timeout,
  input  logic [CNTR_NBITS-1:0] off_timeout,
  input  logic [DGL_NBITS-1:0]  dgl_cnt,
  input  logic                  fault_clr,
  output logic                  pg_ok,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  logic                  pg_f;
  state_t                state, state_nxt;
  logic [CNTR_NBITS-1:0] timer, timer_nxt;
  logic [1:0]            code_nxt;

  pg_deglitch #(
    .DGL_NBITS (DGL_NBITS)
  ) u_deglitch (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .dgl_cnt (dgl_cnt),
    .sig_in  (pg_in),
    .sig_out (pg_f)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    code_nxt  = fault_code;
    case (state)
      S_OFF: begin
        if (en_in) state_nxt = S_WAIT_ON;
      end
      S_WAIT_ON: begin
        if (!en_in) begin
          state_nxt = S_WAIT_OFF;
        end else if (pg_f) begin
          state_nxt = S_ON;
        end else if (tick) begin
          // Compare before increment so the timer can never wrap.
          if (timer == on_timeout) begin
            state_nxt = S_FAULT;
            code_nxt  = FLT_ON_TO;
          end else begin
            timer_nxt = timer + CNTR_NBITS'(1);
          end
        end
      end
      S_ON: begin
        // Disable wins over a simultaneous pg drop: that is a clean shutdown.
        if (!en_in) begin
          state_nxt = S_WAIT_OFF;
        end else if (!pg_f) begin
          state_nxt = S_FAULT;
          code_nxt  = FLT_PG_DROP;
        end
      end
      S_WAIT_OFF: begin
        if (en_in) begin
          state_nxt = S_WAIT_ON;
        end else if (!pg_f) begin
          state_nxt = S_OFF;
        end else if (tick) begin
          if (timer == off_timeout) begin
            state_nxt = S_FAULT;
            code_nxt  = FLT_OFF_TO;
          end else begin
            timer_nxt = timer + CNTR_NBITS'(1);
          end
        end
      end
      S_FAULT: begin
        if (fault_clr && !en_in) begin
          state_nxt = S_OFF;
          code_nxt  = FLT_NONE;
        end
      end
      default: begin
        state_nxt = S_OFF;
        code_nxt  = FLT_NONE;
      end
    endcase
    if (state_nxt != state) timer_nxt = '0;
  end

  // Outputs are decoded from next-state and registered alongside it, so
  // they change on the same edge as the state with no input-to-output path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_OFF;
      timer      <= '0;
      pg_ok      <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      pg_ok      <= (state_nxt == S_ON);
      fault      <= (state_nxt == S_FAULT);
      fault_code <= code_nxt;
    end
  end

endmodule
